rr_select_arbiter: RTL and testbench

Round-robin arbiter that generates the select lines for the 4:1 multiplexer stage. It accepts four request lines, grants one requester at a time, and drives the matching two-bit select (S1, S0), a one-hot grant and a valid flag. The mux consumes S1/S0 directly and its Y output is meaningful only while V is high. Grants are held for a bounded burst, and priority rotates past the previous winner.

---
 rtl/rr_select_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_select_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter
//   Round-robin arbiter driving the select lines of a 4:1 mux stage.
//   Four level-sensitive requesters compete. One winner is granted at a
//   time for at most HOLD_MAX consecutive cycles. Priority rotates to
//   start just past the previous winner.
//
// Parameters
//   HOLD_MAX   maximum consecutive cycles of one grant (1..255)
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   R0..R3     request lines, held high while the source wants the mux
//   S1, S0     mux select; S1:S0 = index of the granted source
//   G0..G3     one-hot grant (at most one high)
//   V          a grant is active; mux output is valid
//   dbg_state  FSM state for observation (0 = IDLE, 1 = GRANT)
//
// Handshake: a source raises R and keeps it high. It owns the mux path on
// every cycle where its G is high. Dropping R ends the grant at the next
// edge. Every output is a flop, so nothing combinational runs from R to
// an output.
module rr_select_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic R0,
   input  logic R1,
   input  logic R2,
   input  logic R3,
   output logic S1,
   output logic S0,
   output logic G0,
   output logic G1,
   output logic G2,
   output logic G3,
   output logic V,
   output logic dbg_state
);

   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MAX);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [1:0]      sel;    // current or most recent grant index
   logic [1:0]      last;   // previous winner, the search starts after it
   logic [CW-1:0]   cnt;
   logic [3:0]      gnt;
   logic            vld;

   logic [3:0]      req;
   logic            any_req;
   logic [1:0]      win;
   logic [1:0]      cand;
   logic            found;
   logic            release_now;

   assign req = {R3, R2, R1, R0};

   // Rotating priority: test last+1 .. last+4 (mod 4). The first hit wins.
   // last+4 wraps to last itself, so a sole requester gets regranted.
   always_comb begin
      any_req = |req;
      win     = last;
      cand    = 2'd0;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   // A request drop and a hold expiry on the same edge give one release.
   assign release_now = !req[sel] || (cnt == HOLD_CNT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         sel   <= 2'd0;
         last  <= 2'd3;   // the first search begins at index 0
         cnt   <= '0;
         gnt   <= 4'b0000;
         vld   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= GRANT;
                  sel   <= win;
                  last  <= win;
                  cnt   <= CW'(1);
                  gnt   <= 4'b0001 << win;
                  vld   <= 1'b1;
               end
            end
            GRANT: begin
               if (!release_now) begin
                  cnt <= cnt + CW'(1);
               end else if (any_req) begin
                  // Back-to-back handover with no idle gap.
                  sel  <= win;
                  last <= win;
                  cnt  <= CW'(1);
                  gnt  <= 4'b0001 << win;
               end else begin
                  // sel keeps the index of the last grant while idle.
                  state <= IDLE;
                  cnt   <= '0;
                  gnt   <= 4'b0000;
                  vld   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               gnt   <= 4'b0000;
               vld   <= 1'b0;
            end
         endcase
      end
   end

   assign S1        = sel[1];
   assign S0        = sel[0];
   assign G0        = gnt[0];
   assign G1        = gnt[1];
   assign G2        = gnt[2];
   assign G3        = gnt[3];
   assign V         = vld;
   assign dbg_state = state;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter
//   Three arbiter instances share one stimulus stream:
//     index 0: HOLD_MAX=4   index 1: HOLD_MAX=1   index 2: HOLD_MAX=2
//   Each stimulus step pushes the outputs expected after the next rising
//   edge for one chosen instance. A monitor pops and compares just after
//   every rising edge. Expected entries are packed as
//   {instance[1:0], V, G3..G0, S1, S0}.
module tb_rr_select_arbiter;

   logic clk;
   logic RST;
   logic R0, R1, R2, R3;

   logic [2:0]       v_w;
   logic [2:0][3:0]  g_w;
   logic [2:0][1:0]  s_w;
   logic [2:0]       dbg_w;

   logic [8:0] exp_q[$];
   string      name_q[$];

   int n_checks;
   int n_fail;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   rr_select_arbiter #(.HOLD_MAX(4)) dut_a (
      .CLK(clk), .RST(RST), .R0(R0), .R1(R1), .R2(R2), .R3(R3),
      .S1(s_w[0][1]), .S0(s_w[0][0]),
      .G0(g_w[0][0]), .G1(g_w[0][1]), .G2(g_w[0][2]), .G3(g_w[0][3]),
      .V(v_w[0]), .dbg_state(dbg_w[0])
   );

   rr_select_arbiter #(.HOLD_MAX(1)) dut_b (
      .CLK(clk), .RST(RST), .R0(R0), .R1(R1), .R2(R2), .R3(R3),
      .S1(s_w[1][1]), .S0(s_w[1][0]),
      .G0(g_w[1][0]), .G1(g_w[1][1]), .G2(g_w[1][2]), .G3(g_w[1][3]),
      .V(v_w[1]), .dbg_state(dbg_w[1])
   );

   rr_select_arbiter #(.HOLD_MAX(2)) dut_c (
      .CLK(clk), .RST(RST), .R0(R0), .R1(R1), .R2(R2), .R3(R3),
      .S1(s_w[2][1]), .S0(s_w[2][0]),
      .G0(g_w[2][0]), .G1(g_w[2][1]), .G2(g_w[2][2]), .G3(g_w[2][3]),
      .V(v_w[2]), .dbg_state(dbg_w[2])
   );

   // ---------------- expected-value helpers ----------------
   function automatic logic [6:0] gr(input logic [1:0] idx);
      logic [3:0] g;
      g = 4'b0001 << idx;
      return {1'b1, g, idx};
   endfunction

   function automatic logic [6:0] idl(input logic [1:0] s);
      return {1'b0, 4'b0000, s};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic rst_v, input logic [3:0] r,
                       input logic [1:0] d, input logic [6:0] e,
                       input string nm);
      @(negedge clk);
      RST = rst_v;
      {R3, R2, R1, R0} = r;
      exp_q.push_back({d, e});
      name_q.push_back(nm);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [8:0] ent;
         string      nm;
         logic [1:0] d;
         logic [6:0] act;
         ent = exp_q.pop_front();
         nm  = name_q.pop_front();
         d   = ent[8:7];
         act = {v_w[d], g_w[d], s_w[d]};
         n_checks++;
         if (act !== ent[6:0]) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got V=%b G=%b S=%b, want V=%b G=%b S=%b",
                     nm, d, act[6], act[5:2], act[1:0],
                     ent[6], ent[5:2], ent[1:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      RST = 1'b1;
      {R3, R2, R1, R0} = 4'b0000;

      // Reset with every request high, then the first grant goes to source 0.
      step(1'b1, 4'b1111, 2'd0, idl(2'd0), "rst_hold_1");
      step(1'b1, 4'b1111, 2'd0, idl(2'd0), "rst_hold_2");
      step(1'b0, 4'b1111, 2'd0, gr(2'd0),  "first_grant_0");
      step(1'b0, 4'b0000, 2'd0, idl(2'd0), "drop_to_idle");

      // Single short request on source 2.
      step(1'b0, 4'b0100, 2'd0, gr(2'd2),  "short_r2_c1");
      step(1'b0, 4'b0100, 2'd0, gr(2'd2),  "short_r2_c2");
      step(1'b0, 4'b0100, 2'd0, gr(2'd2),  "short_r2_c3");
      step(1'b0, 4'b0000, 2'd0, idl(2'd2), "short_r2_idle");
      step(1'b0, 4'b0000, 2'd0, idl(2'd2), "idle_sel_hold");

      // Hold limit 4 with R1 and R3 held: bursts 1,3,1 with no gap.
      step(1'b1, 4'b0000, 2'd0, idl(2'd0), "hold_rst");
      for (int b = 0; b < 3; b++) begin
         for (int c = 0; c < 4; c++) begin
            step(1'b0, 4'b1010, 2'd0, gr((b == 1) ? 2'd3 : 2'd1), "hold_burst");
         end
      end
      step(1'b0, 4'b0000, 2'd0, idl(2'd1), "hold_end_idle");

      // Full rotation with HOLD_MAX=1.
      step(1'b1, 4'b1111, 2'd1, idl(2'd0), "rot_rst");
      step(1'b0, 4'b1111, 2'd1, gr(2'd0),  "rot_0");
      step(1'b0, 4'b1111, 2'd1, gr(2'd1),  "rot_1");
      step(1'b0, 4'b1111, 2'd1, gr(2'd2),  "rot_2");
      step(1'b0, 4'b1111, 2'd1, gr(2'd3),  "rot_3");
      step(1'b0, 4'b1111, 2'd1, gr(2'd0),  "rot_wrap_0");

      // HOLD_MAX=2: R0 drops on the same edge its count hits 2, R2 waiting.
      step(1'b1, 4'b0000, 2'd2, idl(2'd0), "simul_rst");
      step(1'b0, 4'b0101, 2'd2, gr(2'd0),  "simul_g0_c1");
      step(1'b0, 4'b0101, 2'd2, gr(2'd0),  "simul_g0_c2");
      step(1'b0, 4'b0100, 2'd2, gr(2'd2),  "simul_handover_g2");
      step(1'b0, 4'b0100, 2'd2, gr(2'd2),  "simul_g2_c2");
      step(1'b0, 4'b0100, 2'd2, gr(2'd2),  "sole_regrant_g2");
      step(1'b0, 4'b0000, 2'd2, idl(2'd2), "simul_idle");

      // Reset in the second cycle of a G3 grant, then R0 beats R3.
      step(1'b1, 4'b0000, 2'd0, idl(2'd0), "mid_rst_pre");
      step(1'b0, 4'b1000, 2'd0, gr(2'd3),  "mid_g3_c1");
      step(1'b0, 4'b1000, 2'd0, gr(2'd3),  "mid_g3_c2");
      step(1'b1, 4'b1001, 2'd0, idl(2'd0), "mid_rst_apply");
      step(1'b0, 4'b1001, 2'd0, gr(2'd0),  "post_rst_g0");
      step(1'b0, 4'b1001, 2'd0, gr(2'd0),  "post_rst_g0_c2");
      step(1'b0, 4'b0000, 2'd0, idl(2'd0), "post_rst_idle");

      // Let the monitor drain; an undrained queue counts as a failure.
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
